ctr_mod: RTL and testbench
==========================

Name: ctr_mod

Overview:
Parametrised successor to the basic up/down counter. Adds a runtime-programmable modulus, a programmable step, synchronous load, and wrap/saturate mode. It also provides terminal-count and wrap-event outputs so instances can be cascaded. It is intended as the common counter primitive for timers, address generators and prescalers in the datapath.

Parameters:
WIDTH, 8, width of count, max_val and load_value
STEP_W, 4, width of step input (STEP_W <= WIDTH)

Ports:
clk  input  1  rising-edge clock, single clock domain
rst  input  1  reset; asynchronous, active-low (0 = reset asserted)
enable  input  1  count enable; 0 holds count
count_reversed  input  1  direction: 0 = up, 1 = down
saturate  input  1  overflow mode: 0 = wrap modulo max_val+1, 1 = clamp at bound
step  input  STEP_W  increment/decrement amount per enabled cycle; 0 = hold
max_val  input  WIDTH  inclusive upper bound; counting range is 0..max_val
load  input  1  synchronous load strobe
load_value  input  WIDTH  value written on load
count  output  WIDTH  registered count
wrap  output  1  registered one-cycle pulse, high in the cycle after an overflow/underflow event
tc  output  1  combinational terminal count, for cascading

Behaviour:
- Reset (rst=0, async): count=0, wrap=0 immediately. Deassertion is sampled at the next clk rising edge; no count occurs at that edge unless enable is already high.
- Priority per rising edge: load > enable > hold.
- load=1: count <= min(load_value, max_val). wrap <= 0. Direction, enable and step are ignored that cycle.
- enable=0 or step=0: count holds, wrap <= 0.
- Up, enable=1, count <= max_val:
  - If count+step <= max_val: count <= count+step.
  - Otherwise (overflow): wrap mode gives count <= count+step-(max_val+1); saturate mode gives count <= max_val. wrap <= 1 in both modes.
- Down, enable=1, count <= max_val:
  - If count >= step: count <= count-step.
  - Otherwise (underflow): wrap mode gives count <= count+(max_val+1)-step; saturate mode gives count <= 0. wrap <= 1.
- Arithmetic uses WIDTH+1 bits internally; max_val+1 never truncates. With max_val = 2^WIDTH-1, wrap mode equals natural modulo-2^WIDTH counting.
- step > max_val with enable=1: this is always an overflow/underflow. The result is clamped to max_val (up) or 0 (down) regardless of mode, and wrap <= 1.
- Out-of-range count (count > max_val after max_val is lowered at runtime): the next enabled cycle sets count <= max_val in either direction, with wrap <= 0. load still has priority.
- Saturate mode held at the bound: every further enabled cycle re-asserts wrap (the pulse stays high while pushing against the bound).
- tc = enable & (count_reversed ? count==0 : count==max_val). It is combinational and independent of step.
- max_val=0: count stays 0. Every enabled cycle with step != 0 is a wrap event.
- Latency: count and wrap update 1 cycle after the inputs are sampled. Inputs may change every cycle.

Decomposition:
- Package ctr_pkg holds:
  - localparams DIR_UP=1'b0, DIR_DOWN=1'b1, MODE_WRAP=1'b0, MODE_SAT=1'b1;
  - a function clamp(value, bound) used for load and out-of-range handling.
- One sub-module, ctr_next (purely combinational). Inputs: count, step, max_val, direction, saturate. Outputs: next_count and event. ctr_mod keeps the registers, priority logic and tc.

Test Plan (WIDTH=4, STEP_W=2):
1. Reset: assert rst=0 mid-count at count=5 with no clk edge -> count=0 and wrap=0 immediately; release, then enable=1, step=1, up, max_val=15 -> 1,2,...,15,0 with wrap=1 only in the cycle after 15->0.
2. Modulo wrap: max_val=9, step=3, up, wrap mode, from 0 -> 3,6,9,2,5,8,1; wrap pulses after 9->2 and 8->1; tc=1 while count=9.
3. Down wrap vs saturate: max_val=9, step=2, down, from 1 -> wrap mode gives 9 with wrap=1; repeat with saturate=1 -> 0, and 0 again with wrap=1 each enabled cycle.
4. Load priority: load=1, enable=1, load_value=12, max_val=9 -> count=9, wrap=0; next cycle up step=1 -> 0 with wrap=1.
5. Runtime max_val drop: count=14, max_val changed to 6, enable=1, down -> count=6, wrap=0; next cycle -> 5.
6. Hold cases: enable=0 or step=0 over 4 cycles -> count unchanged, wrap=0, tc=0 while enable=0.

Source files
------------

// File: rtl/ctr_pkg.sv
// rtl/ctr_pkg.sv - shared constants and helpers for the ctr_mod counter primitive
package ctr_pkg;

    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Wide enough for any practical counter; callers zero-extend and truncate back.
    localparam int CLAMP_W = 32;

    function automatic logic [CLAMP_W-1:0] clamp(input logic [CLAMP_W-1:0] value,
                                                 input logic [CLAMP_W-1:0] bound);
        return (value > bound) ? bound : value;
    endfunction

endpackage

// File: rtl/ctr_if.sv
// rtl/ctr_if.sv - control and status bundle of the ctr_mod counter
interface ctr_if #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) ();
    logic              enable;
    logic              count_reversed;
    logic              saturate;
    logic [STEP_W-1:0] step;
    logic [WIDTH-1:0]  max_val;
    logic              load;
    logic [WIDTH-1:0]  load_value;
    logic [WIDTH-1:0]  count;
    logic              wrap;
    logic              tc;

    modport master (
        output enable, count_reversed, saturate, step, max_val, load, load_value,
        input  count, wrap, tc
    );

    modport slave (
        input  enable, count_reversed, saturate, step, max_val, load, load_value,
        output count, wrap, tc
    );
endinterface

// File: rtl/ctr_next.sv
// rtl/ctr_next.sv - combinational next-count and wrap-event computation
module ctr_next
    import ctr_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic [WIDTH-1:0]  count,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  max_val,
    input  logic              direction,
    input  logic              saturate,
    output logic [WIDTH-1:0]  next_count,
    output logic              wrap_evt
);
    // One extra bit so max_val+1 and count+step never truncate.
    logic [WIDTH:0] cnt_x;
    logic [WIDTH:0] step_x;
    logic [WIDTH:0] max_x;
    logic [WIDTH:0] mod_x;
    logic [WIDTH:0] sum_x;
    logic [WIDTH:0] res_x;

    assign cnt_x  = {1'b0, count};
    assign step_x = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
    assign max_x  = {1'b0, max_val};
    assign mod_x  = max_x + 1'b1;
    assign sum_x  = cnt_x + step_x;

    always_comb begin
        res_x    = cnt_x;
        wrap_evt = 1'b0;
        if (direction == DIR_DOWN) begin
            if (step_x > max_x) begin
                res_x    = '0;
                wrap_evt = 1'b1;
            end else if (cnt_x >= step_x) begin
                res_x = cnt_x - step_x;
            end else begin
                wrap_evt = 1'b1;
                res_x    = (saturate == MODE_SAT) ? '0 : (cnt_x + mod_x - step_x);
            end
        end else begin
            if (step_x > max_x) begin
                res_x    = max_x;
                wrap_evt = 1'b1;
            end else if (sum_x <= max_x) begin
                res_x = sum_x;
            end else begin
                wrap_evt = 1'b1;
                res_x    = (saturate == MODE_SAT) ? max_x : (sum_x - mod_x);
            end
        end
    end

    assign next_count = res_x[WIDTH-1:0];

endmodule

// File: rtl/ctr_mod.sv
// rtl/ctr_mod.sv - programmable modulus/step up/down counter with wrap and terminal count
module ctr_mod
    import ctr_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic clk,
    input  logic rst,
    ctr_if.slave bus
);
    logic [WIDTH-1:0] next_count;
    logic             wrap_evt;
    logic [WIDTH-1:0] load_clamped;
    logic             out_of_range;

    ctr_next #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_next (
        .count      (bus.count),
        .step       (bus.step),
        .max_val    (bus.max_val),
        .direction  (bus.count_reversed),
        .saturate   (bus.saturate),
        .next_count (next_count),
        .wrap_evt   (wrap_evt)
    );

    assign load_clamped = WIDTH'(clamp(CLAMP_W'(bus.load_value), CLAMP_W'(bus.max_val)));
    assign out_of_range = bus.count > bus.max_val;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.count <= '0;
            bus.wrap  <= 1'b0;
        end else if (bus.load) begin
            bus.count <= load_clamped;
            bus.wrap  <= 1'b0;
        end else if (bus.enable && (bus.step != '0)) begin
            // A lowered max_val pulls the count back into range without flagging a wrap.
            if (out_of_range) begin
                bus.count <= bus.max_val;
                bus.wrap  <= 1'b0;
            end else begin
                bus.count <= next_count;
                bus.wrap  <= wrap_evt;
            end
        end else begin
            bus.wrap <= 1'b0;
        end
    end

    assign bus.tc = bus.enable &
                    ((bus.count_reversed == DIR_DOWN) ? (bus.count == '0)
                                                      : (bus.count == bus.max_val));

endmodule

// File: tb/tb_ctr_mod.sv
// tb/tb_ctr_mod.sv - scoreboard testbench for ctr_mod (WIDTH=4, STEP_W=2)
module tb_ctr_mod;

    logic clk;
    logic rst;

    ctr_if #(.WIDTH(4), .STEP_W(2)) bus ();

    ctr_mod #(.WIDTH(4), .STEP_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0] c;
        logic       w;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every clock produces a new count/wrap; compare against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_checks++;
                if (bus.count !== e.c) begin
                    n_fail++;
                    $display("FAIL count: got %0d expected %0d at %0t", bus.count, e.c, $time);
                end
                n_checks++;
                if (bus.wrap !== e.w) begin
                    n_fail++;
                    $display("FAIL wrap: got %0b expected %0b at %0t", bus.wrap, e.w, $time);
                end
            end
        end
    end

    task automatic cyc(input logic ld, input logic [3:0] lv, input logic en, input logic dir,
                       input logic sat, input logic [1:0] stp, input logic [3:0] mx,
                       input logic [3:0] ec, input logic ew, input int etc);
        exp_t e;
        @(negedge clk);
        rst                = 1'b1;
        bus.load           = ld;
        bus.load_value     = lv;
        bus.enable         = en;
        bus.count_reversed = dir;
        bus.saturate       = sat;
        bus.step           = stp;
        bus.max_val        = mx;
        #1;
        if (etc >= 0) begin
            n_checks++;
            if (bus.tc !== etc[0]) begin
                n_fail++;
                $display("FAIL tc: got %0b expected %0d at %0t", bus.tc, etc, $time);
            end
        end
        e.c = ec;
        e.w = ew;
        sb_q.push_back(e);
    endtask

    initial begin
        logic [3:0] t2_exp [7] = '{4'd3, 4'd6, 4'd9, 4'd2, 4'd5, 4'd8, 4'd1};
        logic       t2_wrp [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        int         wait_cycles;

        rst                = 1'b0;
        bus.load           = 1'b0;
        bus.load_value     = '0;
        bus.enable         = 1'b0;
        bus.count_reversed = 1'b0;
        bus.saturate       = 1'b0;
        bus.step           = '0;
        bus.max_val        = 4'd15;
        #12;
        n_checks++;
        if (bus.count !== 4'd0 || bus.wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_init: got count=%0d wrap=%0b expected 0/0", bus.count, bus.wrap);
        end

        // 1. asynchronous reset mid-count, then full 0..15 wrap
        cyc(1, 4'd5, 0, 0, 0, 2'd0, 4'd15, 4'd5, 0, -1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.count !== 4'd0 || bus.wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got count=%0d wrap=%0b expected 0/0", bus.count, bus.wrap);
        end
        for (int i = 1; i <= 16; i++)
            cyc(0, 4'd0, 1, 0, 0, 2'd1, 4'd15, 4'(i % 16), (i == 16), (i == 16) ? 1 : 0);

        // 2. modulo-10 wrap with step 3
        cyc(1, 4'd0, 0, 0, 0, 2'd3, 4'd9, 4'd0, 0, -1);
        for (int i = 0; i < 7; i++)
            cyc(0, 4'd0, 1, 0, 0, 2'd3, 4'd9, t2_exp[i], t2_wrp[i], (i == 3) ? 1 : 0);

        // 3. down underflow: wrap mode vs saturate mode
        cyc(1, 4'd1, 0, 1, 0, 2'd2, 4'd9, 4'd1, 0, -1);
        cyc(0, 4'd0, 1, 1, 0, 2'd2, 4'd9, 4'd9, 1, 0);
        cyc(1, 4'd1, 0, 1, 1, 2'd2, 4'd9, 4'd1, 0, -1);
        cyc(0, 4'd0, 1, 1, 1, 2'd2, 4'd9, 4'd0, 1, 0);
        cyc(0, 4'd0, 1, 1, 1, 2'd2, 4'd9, 4'd0, 1, 1);

        // 4. load priority and clamp, then overflow from max_val
        cyc(1, 4'd12, 1, 0, 0, 2'd1, 4'd9, 4'd9, 0, -1);
        cyc(0, 4'd0, 1, 0, 0, 2'd1, 4'd9, 4'd0, 1, 1);

        // 5. max_val lowered below the current count
        cyc(1, 4'd14, 0, 0, 0, 2'd1, 4'd15, 4'd14, 0, -1);
        cyc(0, 4'd0, 1, 1, 0, 2'd1, 4'd6, 4'd6, 0, 0);
        cyc(0, 4'd0, 1, 1, 0, 2'd1, 4'd6, 4'd5, 0, 0);

        // 6. hold cases
        cyc(0, 4'd0, 0, 1, 0, 2'd1, 4'd6, 4'd5, 0, 0);
        cyc(0, 4'd0, 0, 0, 0, 2'd3, 4'd5, 4'd5, 0, 0);
        cyc(0, 4'd0, 1, 1, 0, 2'd0, 4'd6, 4'd5, 0, 0);
        cyc(0, 4'd0, 1, 0, 0, 2'd0, 4'd5, 4'd5, 0, 1);

        // max_val=0 and step larger than max_val
        cyc(0, 4'd0, 1, 0, 0, 2'd1, 4'd0, 4'd0, 0, 0);
        cyc(0, 4'd0, 1, 0, 0, 2'd1, 4'd0, 4'd0, 1, 1);
        cyc(0, 4'd0, 1, 0, 0, 2'd3, 4'd1, 4'd1, 1, 0);
        cyc(0, 4'd0, 1, 1, 1, 2'd3, 4'd2, 4'd0, 1, 0);

        wait_cycles = 0;
        while (sb_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
